// File: rtl/rv_pkg.sv
// Shared RV64 control-flow types and constants for the execute-stage branch path.
package rv_pkg;

  localparam int XLEN       = 64;
  localparam int AW         = 32;
  localparam int SHADOW_DEF = 2;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JAL    = 2'd2,
    JALR   = 2'd3
  } br_type_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SHADOW = 1'b1
  } br_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/br_cmp.sv
// Conditional-branch direction evaluator; reserved encodings 010/011 resolve not-taken.
module br_cmp
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: redirect, predictor update, link writeback, squash window.
//   state    | meaning
//   S_IDLE   | accepting control-flow instructions
//   S_SHADOW | redirect in flight; squash high, inputs ignored while counter runs down
module branch_resolve
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int AW     = rv_pkg::AW,
  parameter int SHADOW = rv_pkg::SHADOW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      br_type,
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            pred_taken,
  input  logic [AW-1:0]   pred_target,
  output logic            mispred,
  output logic [AW-1:0]   r_addr,
  output logic            squash,
  output logic            upd_valid,
  output logic [AW-1:0]   upd_pc,
  output logic            upd_taken,
  output logic [AW-1:0]   upd_target,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            exc_misalign
);

  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);

  br_type_t        bt;
  br_state_t       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            cmp_taken, taken, is_jump, misalign, mis, accept;
  logic [XLEN-1:0] jalr_sum;
  logic [AW-1:0]   target, seq_pc, redirect;
  logic [XLEN-AW-1:0] unused_jalr_hi;

  logic            mispred_q, upd_valid_q, upd_taken_q, link_valid_q, exc_q;
  logic [AW-1:0]   r_addr_q, upd_pc_q, upd_target_q;
  logic [XLEN-1:0] link_data_q;

  assign bt = br_type_t'(br_type);

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cmp_taken)
  );

  always_comb begin
    jalr_sum = rs1_data + imm;
    seq_pc   = pc + AW'(4);
    is_jump  = (bt == JAL) || (bt == JALR);
    target   = (bt == JALR) ? {jalr_sum[AW-1:1], 1'b0} : (pc + imm[AW-1:0]);
    taken    = (bt == BRANCH) ? cmp_taken : is_jump;
    misalign = taken && target[1];
    mis      = (taken != pred_taken) || (taken && (target != pred_target));
    redirect = taken ? target : seq_pc;
  end

  assign unused_jalr_hi = jalr_sum[XLEN-1:AW];
  assign accept = in_valid && (bt != NONE) && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (mis || misalign)) begin
          state_d = S_SHADOW;
          cnt_d   = SHADOW_CNT;
        end
      end
      S_SHADOW: begin
        if (cnt_q == 3'd1) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    squash = (state_q == S_SHADOW);
  end

  // Pulses clear every cycle; payload registers only load on an accepted instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispred_q    <= 1'b0;
      exc_q        <= 1'b0;
      upd_valid_q  <= 1'b0;
      link_valid_q <= 1'b0;
      upd_taken_q  <= 1'b0;
      r_addr_q     <= '0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      link_data_q  <= '0;
    end else begin
      mispred_q    <= accept && mis && !misalign;
      exc_q        <= accept && misalign;
      upd_valid_q  <= accept && !misalign;
      link_valid_q <= accept && !misalign && is_jump;
      if (accept) begin
        r_addr_q     <= redirect;
        upd_pc_q     <= pc;
        upd_taken_q  <= taken;
        upd_target_q <= target;
        link_data_q  <= {{(XLEN-AW){1'b0}}, seq_pc};
      end
    end
  end

  assign mispred      = mispred_q;
  assign exc_misalign = exc_q;
  assign upd_valid    = upd_valid_q;
  assign link_valid   = link_valid_q;
  assign upd_taken    = upd_taken_q;
  assign r_addr       = r_addr_q;
  assign upd_pc       = upd_pc_q;
  assign upd_target   = upd_target_q;
  assign link_data    = link_data_q;

endmodule
